demux_1_4_stream: RTL
=====================

DEMUX_1_4_STREAM -- requirements
Module: demux_1_4_stream

Interface
REQ-001 Parameter WIDTH, default 4; data width of the input and of every output channel.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  input word present.
REQ-005 in_ready  output  1  block accepts the input word this cycle.
REQ-006 in_data  input  WIDTH  input word.
REQ-007 in_sel  input  2  destination channel index, 0..3.
REQ-008 out_valid  output  4  bit i: channel i holds a word.
REQ-009 out_ready  input  4  bit i: consumer i takes the word this cycle.
REQ-010 out_data0, out_data1, out_data2, out_data3  output  WIDTH each  channel words.

Function
REQ-011 Input transfer SHALL occur on a rising edge when in_valid && in_ready; output transfer on channel i when out_valid[i] && out_ready[i].
REQ-012 Each channel SHALL hold a one-entry register (valid flag + WIDTH data); four channels, independent.
REQ-013 in_ready SHALL equal !out_valid[in_sel] || out_ready[in_sel]; combinational from in_sel, out_valid and out_ready only, never from in_valid.
REQ-014 An accepted word SHALL appear on out_data[in_sel] with out_valid[in_sel]=1 on the cycle after the transfer edge; latency exactly 1 cycle.
REQ-015 Channels not equal to in_sel SHALL be unaffected by an input transfer.
REQ-016 While out_valid[i]=1 and out_ready[i]=0, out_data_i SHALL stay stable and out_valid[i] SHALL stay 1.
REQ-017 A channel that is full, has out_ready=1, and receives an input transfer in the same cycle SHALL drain and load together; out_valid stays 1 and data takes the new word.
REQ-018 A channel that drains with no input transfer SHALL clear out_valid on the next edge; out_data keeps its last value.
REQ-019 Output transfers on several channels in one cycle SHALL all complete.
REQ-020 in_sel and in_data MAY change while in_valid=1 and in_ready=0; no word SHALL be taken until a transfer edge.
REQ-021 No word SHALL be lost, duplicated or routed to any channel other than in_sel sampled at its transfer edge.
REQ-022 in_valid=0 SHALL cause no state change except drains.

Reset
REQ-023 When rst=1 at an edge, all out_valid SHALL be 0 and all out_data SHALL be 0 after that edge.
REQ-024 Reset SHALL take priority over simultaneous input and output transfers; in-flight words are discarded.
REQ-025 During rst=1, in_ready SHALL follow REQ-013 using the registered state (1 after the first reset edge).

Structure
REQ-026 A shared package SHALL hold the channel count constant (4), the select width (2) and the default WIDTH (4).
REQ-027 One sub-module demux_slot (one-entry valid/data register with load, drain, WIDTH parameter) SHALL be instantiated four times; decode and in_ready mux live in the top.

Verification
REQ-028 Reset, then in_data=4'ha sel 0, 4'hb sel 1, 4'hc sel 2, 4'hd sel 3, out_ready=4'b1111 -> each word on its channel one cycle after acceptance; in_ready stays 1.
REQ-029 out_ready=0, send 4'h7 sel 2 -> out_valid=4'b0100, out_data2=7; second word 4'h3 sel 2 -> in_ready=0, out_data2 stays 7 for 5 cycles.
REQ-030 Channel 2 full (7), out_ready[2]=1, in 4'h3 sel 2 in same cycle -> out_valid[2] stays 1, out_data2=3 next cycle.
REQ-031 Channel 0 full and blocked, in sel switched from 0 to 1 while stalled -> in_ready rises, 4'h9 lands on channel 1, channel 0 keeps its word.
REQ-032 rst=1 with all four channels full and in_valid=1 -> out_valid=0, all out_data=0 next cycle; no word accepted.
REQ-033 Random stimulus 1000 cycles, random out_ready -> per-channel scoreboard: order preserved, no loss, no duplication.

Source files
------------

// File: rtl/demux_1_4_stream_pkg.sv
// Shared constants and helpers for the 1-to-4 stream demultiplexer.
package demux_1_4_stream_pkg;

  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned DEF_WIDTH = 4;

  function automatic logic [NUM_CH-1:0] sel_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/demux_1_4_stream_slot.sv
// One-entry valid/data holding register for a single demux output channel.
module demux_slot #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Load wins over drain so a simultaneous drain+load keeps the slot full.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1_4_stream.sv
// 1-to-4 valid/ready stream demultiplexer: each accepted word is routed to the
// one-entry slot selected by in_sel and presented one cycle later.
module demux_1_4_stream
  import demux_1_4_stream_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SEL_W-1:0]  in_sel,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [WIDTH-1:0]  out_data0,
  output logic [WIDTH-1:0]  out_data1,
  output logic [WIDTH-1:0]  out_data2,
  output logic [WIDTH-1:0]  out_data3
);

  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] drain;
  logic [WIDTH-1:0]  slot_data [NUM_CH];
  logic              in_xfer;

  // Ready depends only on the selected slot's state, never on in_valid.
  always_comb begin
    in_ready = !out_valid[in_sel] || out_ready[in_sel];
    in_xfer  = in_valid && in_ready;
    load     = in_xfer ? sel_decode(in_sel) : '0;
    drain    = out_valid & out_ready;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[g]),
      .load_data (in_data),
      .drain     (drain[g]),
      .valid     (out_valid[g]),
      .data      (slot_data[g])
    );
  end

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];

endmodule
